// File: rtl/fft_bitrev_reorder_if.sv
// Sample-stream bundle for the FFT bit-reversal reorder stage.
// The bench/upstream side drives the i_* group; the reorder stage drives the o_* group.
interface fft_bitrev_reorder_if #(
  parameter int WIDTH = 32
);
  logic             i_ce;
  logic [3:0]       i_lgsize;
  logic             i_bypass;
  logic             i_sync;
  logic [WIDTH-1:0] i_sample;
  logic [WIDTH-1:0] o_result;
  logic             o_sync;
  logic             o_err;

  modport master (
    output i_ce, i_lgsize, i_bypass, i_sync, i_sample,
    input  o_result, o_sync, o_err
  );

  modport slave (
    input  i_ce, i_lgsize, i_bypass, i_sync, i_sample,
    output o_result, o_sync, o_err
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder: one bank is written in natural order while the
// other is read bit-reversed (or natural in bypass); frame size is chosen per frame.
//   state | meaning
//   IDLE  | waiting for the first i_sync, samples discarded
//   FILL  | buffering a frame, no output
//   RUN   | writing frame k+1 while reading frame k from the other bank
module fft_bitrev_reorder #(
  parameter int WIDTH     = 32,
  parameter int LGMAXSIZE = 10
) (
  input logic               i_clk,
  input logic               i_reset,
  fft_bitrev_reorder_if.slave bus
);
  localparam int MAXN = 1 << LGMAXSIZE;
  localparam int AW   = LGMAXSIZE + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t               state;
  logic                 bank;
  logic [LGMAXSIZE-1:0] wr_idx;
  logic [3:0]           wr_lg, rd_lg;
  logic                 wr_byp, rd_byp;
  logic                 rd_valid, rd_first;
  logic [WIDTH-1:0]     mem [2*MAXN];
  logic [WIDTH-1:0]     rd_data;

  function automatic logic [3:0] clamp_lg(input logic [3:0] lg);
    if (lg < 4'd2) return 4'd2;
    if (lg > 4'(LGMAXSIZE)) return 4'(LGMAXSIZE);
    return lg;
  endfunction

  logic [3:0]           req_lg;
  logic                 accept, misalign, frame_start, mode_match, rd_en;
  logic [LGMAXSIZE-1:0] wr_last_idx, rev_full, rd_rev;
  logic [AW-1:0]        wr_addr, rd_addr;

  assign req_lg      = clamp_lg(bus.i_lgsize);
  assign accept      = bus.i_ce && (state != IDLE || bus.i_sync);
  assign misalign    = bus.i_ce && bus.i_sync && state != IDLE && wr_idx != '0;
  assign frame_start = accept && (state == IDLE || misalign || wr_idx == '0);
  assign mode_match  = (req_lg == rd_lg) && (bus.i_bypass == rd_byp);
  // A size/mode change at a frame boundary drops the pending frame instead of reading it.
  assign rd_en       = bus.i_ce && state == RUN && !misalign && (wr_idx != '0 || mode_match);
  assign wr_last_idx = {LGMAXSIZE{1'b1}} >> (4'(LGMAXSIZE) - wr_lg);

  always_comb begin
    rev_full = '0;
    for (int i = 0; i < LGMAXSIZE; i++) rev_full[i] = wr_idx[LGMAXSIZE-1-i];
  end

  assign rd_rev  = rev_full >> (4'(LGMAXSIZE) - rd_lg);
  assign wr_addr = {bank, misalign ? {LGMAXSIZE{1'b0}} : wr_idx};
  assign rd_addr = {~bank, rd_byp ? wr_idx : rd_rev};

  always_ff @(posedge i_clk) begin
    if (bus.i_ce) begin
      if (accept) mem[wr_addr] <= bus.i_sample;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      bank         <= 1'b0;
      wr_idx       <= '0;
      wr_lg        <= 4'd2;
      rd_lg        <= 4'd2;
      wr_byp       <= 1'b0;
      rd_byp       <= 1'b0;
      rd_valid     <= 1'b0;
      rd_first     <= 1'b0;
      bus.o_result <= '0;
      bus.o_sync   <= 1'b0;
      bus.o_err    <= 1'b0;
    end else if (bus.i_ce) begin
      rd_valid   <= rd_en;
      rd_first   <= rd_en && wr_idx == '0;
      bus.o_err  <= misalign;
      bus.o_sync <= rd_valid && rd_first && !misalign;
      if (rd_valid) bus.o_result <= rd_data;
      if (accept) begin
        if (frame_start) begin
          wr_lg  <= req_lg;
          wr_byp <= bus.i_bypass;
        end
        if (misalign || state == IDLE || (state == RUN && wr_idx == '0 && !mode_match)) begin
          wr_idx <= {{(LGMAXSIZE-1){1'b0}}, 1'b1};
          state  <= FILL;
        end else if (wr_idx == wr_last_idx) begin
          wr_idx <= '0;
          bank   <= ~bank;
          rd_lg  <= wr_lg;
          rd_byp <= wr_byp;
          state  <= RUN;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the bit-reversal reorder stage: ordering, bypass, clamp,
// resync, clock-enable gaps, size change and mid-run reset.
module tb_fft_bitrev_reorder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   br3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   br2 [4] = '{0, 2, 1, 3};

  fft_bitrev_reorder_if #(.WIDTH(32)) bus ();

  fft_bitrev_reorder #(.WIDTH(32), .LGMAXSIZE(10)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] smp(input int f, input int p);
    return {8'hA5, f[7:0], p[15:0]};
  endfunction

  task automatic cyc(input logic ce, input logic sync, input logic [31:0] s);
    bus.i_ce = ce;
    bus.i_sync = sync;
    bus.i_sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_lgsize = 4'd3;
    bus.i_bypass = 1'b0;
    cyc(1'b1, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (bus.o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.o_result); end
    checks++;
    if (bus.o_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b expected 0", bus.o_sync); end
    checks++;
    if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.o_err); end
    reset = 1'b0;
  endtask

  // Sync only on even frames: a missing sync at index 0 must be tolerated.
  task automatic test_reorder(input logic byp);
    int f, p, j;
    logic [31:0] exp;
    do_reset();
    bus.i_lgsize = 4'd3;
    bus.i_bypass = byp;
    for (int k = 0; k < 32; k++) begin
      f = k / 8;
      p = k % 8;
      cyc(1'b1, p == 0 && f % 2 == 0, smp(f, p));
      if (k >= 9) begin
        j = k - 9;
        exp = smp(j / 8, byp ? j % 8 : br3[j % 8]);
        checks++;
        if (bus.o_result !== exp) begin errors++; $display("FAIL reorder_result byp=%0b k=%0d: got %h expected %h", byp, k, bus.o_result, exp); end
        checks++;
        if (bus.o_sync !== (j % 8 == 0)) begin errors++; $display("FAIL reorder_sync byp=%0b k=%0d: got %b expected %b", byp, k, bus.o_sync, j % 8 == 0); end
      end else begin
        checks++;
        if (bus.o_sync !== 1'b0) begin errors++; $display("FAIL reorder_early_sync byp=%0b k=%0d: got %b expected 0", byp, k, bus.o_sync); end
      end
      checks++;
      if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reorder_err byp=%0b k=%0d: got %b expected 0", byp, k, bus.o_err); end
    end
  endtask

  task automatic test_clamp();
    int j;
    logic [31:0] exp;
    do_reset();
    bus.i_lgsize = 4'd1;
    bus.i_bypass = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, k % 4 == 0, smp(k / 4, k % 4));
      if (k >= 5) begin
        j = k - 5;
        exp = smp(j / 4, br2[j % 4]);
        checks++;
        if (bus.o_result !== exp) begin errors++; $display("FAIL clamp_result k=%0d: got %h expected %h", k, bus.o_result, exp); end
        checks++;
        if (bus.o_sync !== (j % 4 == 0)) begin errors++; $display("FAIL clamp_sync k=%0d: got %b expected %b", k, bus.o_sync, j % 4 == 0); end
      end
    end
  endtask

  task automatic test_misalign();
    int f, p;
    logic [31:0] exp;
    do_reset();
    bus.i_lgsize = 4'd3;
    bus.i_bypass = 1'b0;
    for (int k = 0; k < 29; k++) begin
      if (k < 8) begin f = 0; p = k; end
      else if (k < 13) begin f = 1; p = k - 8; end
      else if (k < 21) begin f = 2; p = k - 13; end
      else begin f = 3; p = k - 21; end
      cyc(1'b1, p == 0, smp(f, p));
      checks++;
      if (bus.o_err !== (k == 13)) begin errors++; $display("FAIL misalign_err k=%0d: got %b expected %b", k, bus.o_err, k == 13); end
      if (k >= 9 && k <= 13) exp = smp(0, br3[k - 9]);
      else if (k >= 14 && k <= 21) exp = smp(0, br3[4]);
      else if (k >= 22) exp = smp(2, br3[k - 22]);
      else exp = 32'h0;
      checks++;
      if (bus.o_result !== exp) begin errors++; $display("FAIL misalign_result k=%0d: got %h expected %h", k, bus.o_result, exp); end
      checks++;
      if (bus.o_sync !== (k == 9 || k == 22)) begin errors++; $display("FAIL misalign_sync k=%0d: got %b expected %b", k, bus.o_sync, k == 9 || k == 22); end
    end
  endtask

  task automatic test_ce_gaps();
    int n_ce, j, it;
    logic [31:0] exp, prev_res;
    logic prev_sync;
    do_reset();
    bus.i_lgsize = 4'd3;
    bus.i_bypass = 1'b0;
    n_ce = 0;
    it = 0;
    prev_res = bus.o_result;
    prev_sync = bus.o_sync;
    while (n_ce < 32 && it < 400) begin
      it++;
      if ($urandom_range(0, 1) == 1) begin
        cyc(1'b1, n_ce % 8 == 0, smp(n_ce / 8, n_ce % 8));
        if (n_ce >= 9) begin
          j = n_ce - 9;
          exp = smp(j / 8, br3[j % 8]);
          checks++;
          if (bus.o_result !== exp) begin errors++; $display("FAIL gaps_result ce=%0d: got %h expected %h", n_ce, bus.o_result, exp); end
          checks++;
          if (bus.o_sync !== (j % 8 == 0)) begin errors++; $display("FAIL gaps_sync ce=%0d: got %b expected %b", n_ce, bus.o_sync, j % 8 == 0); end
        end else begin
          checks++;
          if (bus.o_sync !== 1'b0) begin errors++; $display("FAIL gaps_early_sync ce=%0d: got %b expected 0", n_ce, bus.o_sync); end
        end
        n_ce++;
      end else begin
        cyc(1'b0, 1'($urandom_range(0, 1)), $urandom);
        checks++;
        if (bus.o_result !== prev_res) begin errors++; $display("FAIL gaps_hold_result it=%0d: got %h expected %h", it, bus.o_result, prev_res); end
        checks++;
        if (bus.o_sync !== prev_sync) begin errors++; $display("FAIL gaps_hold_sync it=%0d: got %b expected %b", it, bus.o_sync, prev_sync); end
      end
      checks++;
      if (bus.o_err !== 1'b0) begin errors++; $display("FAIL gaps_err it=%0d: got %b expected 0", it, bus.o_err); end
      prev_res = bus.o_result;
      prev_sync = bus.o_sync;
    end
    checks++;
    if (n_ce < 32) begin errors++; $display("FAIL gaps_budget: got %0d ce cycles expected 32", n_ce); end
  endtask

  task automatic test_size_change();
    int f, p;
    logic [31:0] exp;
    do_reset();
    bus.i_bypass = 1'b0;
    for (int k = 0; k <= 1044; k++) begin
      bus.i_lgsize = (k < 12) ? 4'd3 : 4'd10;
      if (k < 8) begin f = 0; p = k; end
      else if (k < 16) begin f = 1; p = k - 8; end
      else if (k < 1040) begin f = 2; p = k - 16; end
      else begin f = 3; p = k - 1040; end
      cyc(1'b1, p == 0, smp(f, p));
      if (k >= 9 && k <= 16) begin
        exp = smp(0, br3[k - 9]);
        checks++;
        if (bus.o_result !== exp) begin errors++; $display("FAIL size_small_result k=%0d: got %h expected %h", k, bus.o_result, exp); end
        checks++;
        if (bus.o_sync !== (k == 9)) begin errors++; $display("FAIL size_small_sync k=%0d: got %b expected %b", k, bus.o_sync, k == 9); end
      end else if (k >= 17 && k <= 1040) begin
        checks++;
        if (bus.o_result !== smp(0, 7) || bus.o_sync !== 1'b0) begin
          errors++;
          $display("FAIL size_fill_hold k=%0d: got %h/%b expected %h/0", k, bus.o_result, bus.o_sync, smp(0, 7));
        end
      end else if (k >= 1041) begin
        case (k)
          1041: exp = smp(2, 0);
          1042: exp = smp(2, 512);
          1043: exp = smp(2, 256);
          default: exp = smp(2, 768);
        endcase
        checks++;
        if (bus.o_result !== exp) begin errors++; $display("FAIL size_large_result k=%0d: got %h expected %h", k, bus.o_result, exp); end
        checks++;
        if (bus.o_sync !== (k == 1041)) begin errors++; $display("FAIL size_large_sync k=%0d: got %b expected %b", k, bus.o_sync, k == 1041); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int j;
    logic [31:0] exp;
    do_reset();
    bus.i_lgsize = 4'd3;
    bus.i_bypass = 1'b0;
    for (int k = 0; k < 12; k++) cyc(1'b1, k % 8 == 0, smp(k / 8, k % 8));
    checks++;
    if (bus.o_result !== smp(0, br3[2])) begin errors++; $display("FAIL midreset_pre: got %h expected %h", bus.o_result, smp(0, br3[2])); end
    reset = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    checks++;
    if (bus.o_result !== 32'h0 || bus.o_sync !== 1'b0 || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got %h/%b/%b expected 0/0/0", bus.o_result, bus.o_sync, bus.o_err);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, smp(7, k));
      checks++;
      if (bus.o_result !== 32'h0 || bus.o_sync !== 1'b0) begin
        errors++;
        $display("FAIL midreset_idle k=%0d: got %h/%b expected 0/0", k, bus.o_result, bus.o_sync);
      end
    end
    for (int m = 0; m < 16; m++) begin
      cyc(1'b1, m % 8 == 0, smp(8 + m / 8, m % 8));
      if (m >= 9) begin
        j = m - 9;
        exp = smp(8 + j / 8, br3[j % 8]);
      end else begin
        exp = 32'h0;
      end
      checks++;
      if (bus.o_result !== exp) begin errors++; $display("FAIL midreset_result m=%0d: got %h expected %h", m, bus.o_result, exp); end
      checks++;
      if (bus.o_sync !== (m == 9)) begin errors++; $display("FAIL midreset_sync m=%0d: got %b expected %b", m, bus.o_sync, m == 9); end
    end
  endtask

  initial begin
    bus.i_ce = 1'b0;
    bus.i_sync = 1'b0;
    bus.i_sample = '0;
    bus.i_lgsize = 4'd3;
    bus.i_bypass = 1'b0;
    test_reset();
    test_reorder(1'b0);
    test_reorder(1'b1);
    test_clamp();
    test_misalign();
    test_ce_gaps();
    test_size_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
